// File: rtl/memory_write_access.sv
// Store-side memory controller: splits a 48-bit request into 1-3 sequential
// 16-bit beats to the kernel (K) or picture (P) memory, then holds HANDSHAKE.
module memory_write_access #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 48,
    parameter int unsigned WORD_W      = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              ENABLE,
    input  logic [2:0]        CTRL,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] WRITE_DATA,
    output logic              HANDSHAKE,
    output logic              MEM_WE_K,
    output logic              MEM_WE_P,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [WORD_W-1:0] MEM_WDATA
);

    typedef enum logic [1:0] {IDLE, WRITE, GAP, DONE} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] data_q;
    logic              target;
    logic [1:0]        last_idx;
    logic [1:0]        idx;
    logic [1:0]        idx_next;
    logic [3:0]        cnt;
    logic              advance;
    logic [WORD_W-1:0] beat_next;
    logic [ADDR_W-1:0] address_q;
    logic [WORD_W-1:0] wdata_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (ENABLE) state_next = WRITE;
            WRITE: begin
                if (!ENABLE)                state_next = IDLE;
                else if (idx == last_idx)   state_next = DONE;
                else if (WAIT_CYCLES == 0)  state_next = WRITE;
                else                        state_next = GAP;
            end
            GAP: begin
                if (!ENABLE)        state_next = IDLE;
                else if (cnt == 4'd1) state_next = WRITE;
            end
            DONE:  if (!ENABLE) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moving to the following beat, either back-to-back or at the end of a gap.
    assign advance  = (state == WRITE || state == GAP) && state_next == WRITE;
    assign idx_next = idx + 2'd1;

    always_comb begin
        beat_next = data_q[WORD_W-1:0];
        case (idx_next)
            2'd1:    beat_next = data_q[WORD_W +: WORD_W];
            2'd2:    beat_next = data_q[2*WORD_W +: WORD_W];
            default: beat_next = data_q[WORD_W-1:0];
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            data_q    <= '0;
            target    <= 1'b0;
            last_idx  <= '0;
            idx       <= '0;
            cnt       <= '0;
            address_q <= '0;
            wdata_q   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && ENABLE) begin
                data_q    <= WRITE_DATA;
                target    <= CTRL[0];
                last_idx  <= (CTRL[2:1] == 2'b11) ? 2'd2 : CTRL[2:1];
                idx       <= '0;
                address_q <= ADDRESS;
                wdata_q   <= WRITE_DATA[WORD_W-1:0];
            end
            if (state == WRITE && state_next == GAP)
                cnt <= 4'(WAIT_CYCLES);
            else if (state == GAP)
                cnt <= cnt - 4'd1;
            if (advance) begin
                idx       <= idx_next;
                address_q <= address_q + ADDR_W'(1);
                wdata_q   <= beat_next;
            end
            // Address/data buses return to zero whenever the controller goes idle.
            if (state != IDLE && state_next == IDLE) begin
                address_q <= '0;
                wdata_q   <= '0;
            end
        end
    end

    assign HANDSHAKE   = (state == DONE);
    assign MEM_WE_K    = (state == WRITE) && !target;
    assign MEM_WE_P    = (state == WRITE) && target;
    assign MEM_ADDRESS = address_q;
    assign MEM_WDATA   = wdata_q;

endmodule

// File: tb/tb_memory_write_access.sv
// Directed self-checking bench for memory_write_access (WAIT_CYCLES 0 and 2).
module tb_memory_write_access;

    logic        CLK;
    logic        RESET_N;
    logic        ENABLE;
    logic        en2;
    logic [2:0]  CTRL;
    logic [31:0] ADDRESS;
    logic [47:0] WRITE_DATA;

    logic        hs, we_k, we_p;
    logic [31:0] maddr;
    logic [15:0] mdata;
    logic        hs2, we_k2, we_p2;
    logic [31:0] maddr2;
    logic [15:0] mdata2;

    int checks = 0;
    int errors = 0;

    memory_write_access #(.ADDR_W(32), .DATA_W(48), .WORD_W(16), .WAIT_CYCLES(0)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(ENABLE), .CTRL(CTRL),
        .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA), .HANDSHAKE(hs),
        .MEM_WE_K(we_k), .MEM_WE_P(we_p), .MEM_ADDRESS(maddr), .MEM_WDATA(mdata)
    );

    memory_write_access #(.ADDR_W(32), .DATA_W(48), .WORD_W(16), .WAIT_CYCLES(2)) dut2 (
        .CLK(CLK), .RESET_N(RESET_N), .ENABLE(en2), .CTRL(CTRL),
        .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA), .HANDSHAKE(hs2),
        .MEM_WE_K(we_k2), .MEM_WE_P(we_p2), .MEM_ADDRESS(maddr2), .MEM_WDATA(mdata2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // we_k, we_p, address, data, handshake of the WAIT_CYCLES=0 instance
    task automatic chk0(input string tag, input logic ek, input logic ep,
                        input logic [31:0] a, input logic [15:0] d, input logic h);
        chk({tag, ".we_k"}, 64'(we_k), 64'(ek));
        chk({tag, ".we_p"}, 64'(we_p), 64'(ep));
        chk({tag, ".addr"}, 64'(maddr), 64'(a));
        chk({tag, ".data"}, 64'(mdata), 64'(d));
        chk({tag, ".hs"},   64'(hs),   64'(h));
    endtask

    initial begin
        RESET_N    = 1'b0;
        ENABLE     = 1'b0;
        en2        = 1'b0;
        CTRL       = 3'b000;
        ADDRESS    = '0;
        WRITE_DATA = '0;
        tick();
        tick();
        chk0("rst", 0, 0, 32'h0, 16'h0, 0);
        chk("rst.hs2", 64'(hs2), 64'd0);
        RESET_N = 1'b1;
        tick();

        // 3-beat write to K
        ADDRESS = 32'h100; WRITE_DATA = 48'hCCCC_BBBB_AAAA; CTRL = 3'b100; ENABLE = 1'b1;
        tick(); chk0("k3.c1", 1, 0, 32'h100, 16'hAAAA, 0);
        tick(); chk0("k3.c2", 1, 0, 32'h101, 16'hBBBB, 0);
        tick(); chk0("k3.c3", 1, 0, 32'h102, 16'hCCCC, 0);
        ADDRESS = 32'hDEAD; WRITE_DATA = 48'h1; CTRL = 3'b001;
        tick(); chk("k3.c4.hs", 64'(hs), 64'd1); chk("k3.c4.we_k", 64'(we_k), 64'd0);
        tick(); chk("k3.c5.hs", 64'(hs), 64'd1);
        tick(); chk("k3.c6.hs", 64'(hs), 64'd1);
        ENABLE = 1'b0;
        tick(); chk0("k3.c7", 0, 0, 32'h0, 16'h0, 0);

        // single beat to P
        ADDRESS = 32'h20; WRITE_DATA = 48'h0000_0000_1234; CTRL = 3'b001; ENABLE = 1'b1;
        tick(); chk0("p1.c1", 0, 1, 32'h20, 16'h1234, 0);
        tick(); chk("p1.c2.hs", 64'(hs), 64'd1); chk("p1.c2.we_p", 64'(we_p), 64'd0);
        ENABLE = 1'b0;
        tick(); chk0("p1.c3", 0, 0, 32'h0, 16'h0, 0);

        // WAIT_CYCLES=2, 2 beats to K
        ADDRESS = 32'h40; WRITE_DATA = 48'h0000_2222_1111; CTRL = 3'b010; en2 = 1'b1;
        tick();
        chk("w2.c1.we", 64'(we_k2), 64'd1); chk("w2.c1.addr", 64'(maddr2), 64'h40);
        chk("w2.c1.data", 64'(mdata2), 64'h1111);
        tick();
        chk("w2.c2.we", 64'(we_k2), 64'd0); chk("w2.c2.addr", 64'(maddr2), 64'h40);
        chk("w2.c2.data", 64'(mdata2), 64'h1111);
        tick();
        chk("w2.c3.we", 64'(we_k2), 64'd0); chk("w2.c3.hs", 64'(hs2), 64'd0);
        tick();
        chk("w2.c4.we", 64'(we_k2), 64'd1); chk("w2.c4.addr", 64'(maddr2), 64'h41);
        chk("w2.c4.data", 64'(mdata2), 64'h2222); chk("w2.c4.we_p", 64'(we_p2), 64'd0);
        tick();
        chk("w2.c5.hs", 64'(hs2), 64'd1); chk("w2.c5.we", 64'(we_k2), 64'd0);
        en2 = 1'b0;
        tick();
        chk("w2.c6.hs", 64'(hs2), 64'd0);
        chk("w2.dut0_idle", 64'(we_k | we_p | hs), 64'd0);

        // abort after the first beat
        ADDRESS = 32'h200; WRITE_DATA = 48'h0C0C_0B0B_0A0A; CTRL = 3'b100; ENABLE = 1'b1;
        tick(); chk0("ab.c1", 1, 0, 32'h200, 16'h0A0A, 0);
        ENABLE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); chk0("ab.idle", 0, 0, 32'h0, 16'h0, 0);
        end
        chk("ab.state", 64'(dut.state), 64'd0);
        ADDRESS = 32'h300; WRITE_DATA = 48'h0000_0000_BEEF; CTRL = 3'b001; ENABLE = 1'b1;
        tick(); chk0("ab.new.c1", 0, 1, 32'h300, 16'hBEEF, 0);
        tick(); chk("ab.new.hs", 64'(hs), 64'd1);
        ENABLE = 1'b0;
        tick(); chk("ab.new.hs_off", 64'(hs), 64'd0);

        // address wrap, size 11 -> 3 beats, held ENABLE must not retrigger
        ADDRESS = 32'hFFFF_FFFF; WRITE_DATA = 48'h3333_2222_1111; CTRL = 3'b110; ENABLE = 1'b1;
        tick(); chk0("wr.c1", 1, 0, 32'hFFFF_FFFF, 16'h1111, 0);
        tick(); chk0("wr.c2", 1, 0, 32'h0, 16'h2222, 0);
        tick(); chk0("wr.c3", 1, 0, 32'h1, 16'h3333, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("wr.hold.we", 64'(we_k | we_p), 64'd0);
            chk("wr.hold.hs", 64'(hs), 64'd1);
        end
        ENABLE = 1'b0;
        tick(); chk("wr.hs_off", 64'(hs), 64'd0);

        // asynchronous reset during the first beat
        ADDRESS = 32'h500; WRITE_DATA = 48'h0003_0002_0001; CTRL = 3'b100; ENABLE = 1'b1;
        tick(); chk0("ar.c1", 1, 0, 32'h500, 16'h0001, 0);
        #2;
        RESET_N = 1'b0;
        #1;
        chk0("ar.cut", 0, 0, 32'h0, 16'h0, 0);
        ENABLE = 1'b0;
        tick();
        #2;
        RESET_N = 1'b1;
        tick();
        chk("ar.state", 64'(dut.state), 64'd0);
        chk0("ar.idle", 0, 0, 32'h0, 16'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
